uart_apb_sequencer: RTL and testbench

- APB master that configures and services one CoreUARTapb instance.
- After reset, and on request, it programs the baud/mode registers.
- It then continuously polls status, drains received bytes into a one-entry output register, and round-robin arbitrates two byte-stream requesters onto the UART transmit register.
- Sits between user logic (command/telemetry streams) and the UART APB slave. It is the only APB master on that slave.

---
 rtl/uart_apb_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: the only APB master for one CoreUARTapb slave.
// After reset, and whenever cfg_start is seen, it writes the baud/mode
// registers. It then polls status back-to-back, drains received bytes into a
// one-entry output register, and round-robins two byte requesters onto TX.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   PSEL..PWDATA            APB master request (all registered)
//   PRDATA, PREADY          APB slave response
//   cfg_start / cfg_done    reprogram request / configuration written
//   txN_valid/data/ready    byte requesters; ready is a one-cycle accept pulse
//   rx_valid/data/err/ready received byte, {framing, overflow, parity}, accept
module uart_apb_sequencer #(
    parameter logic [12:0] BAUD_VALUE        = 13'd0,
    parameter bit          BIT8              = 1'b1,
    parameter bit          PARITY_EN         = 1'b0,
    parameter bit          ODD_N_EVEN        = 1'b0,
    parameter bit          BAUD_VAL_FRCTN_EN = 1'b0,
    parameter logic [2:0]  BAUD_VAL_FRCTN    = 3'd0
) (
    input  logic       PCLK,
    input  logic       PRESET,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       cfg_start,
    output logic       cfg_done,
    input  logic       tx0_valid,
    input  logic [7:0] tx0_data,
    output logic       tx0_ready,
    input  logic       tx1_valid,
    input  logic [7:0] tx1_data,
    output logic       tx1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [2:0] rx_err,
    input  logic       rx_ready
);

    typedef enum logic [2:0] {StCfg1, StCfg2, StCfg3, StPoll, StRxRd, StTxWr} state_e;

    localparam logic [4:0] AddrTx    = 5'h00;
    localparam logic [4:0] AddrRx    = 5'h04;
    localparam logic [4:0] AddrCtrl1 = 5'h08;
    localparam logic [4:0] AddrCtrl2 = 5'h0C;
    localparam logic [4:0] AddrStat  = 5'h10;
    localparam logic [4:0] AddrFrac  = 5'h14;

    state_e     state_q;
    logic       psel_q, penable_q, pwrite_q;
    logic [4:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       cfg_done_q;
    logic       pend_q;      // cfg_start seen, not yet acted on
    logic       ptr_q;       // requester granted last
    logic       grant_q;     // requester owning the TX write in flight
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic [2:0] rx_err_q;
    logic [2:0] stat_err_q;  // error bits from the most recent poll

    state_e     st_d;
    state_e     issue_st;
    logic       pend;
    logic       gnt_sel;
    logic       issue_write;
    logic [4:0] issue_addr;
    logic [7:0] issue_wdata;

    always_comb begin
        pend    = pend_q | cfg_start;
        // Both valid: the one not granted last. Otherwise the single valid one.
        gnt_sel = (tx0_valid & tx1_valid) ? ~ptr_q : ~tx0_valid;

        st_d = state_q;
        unique case (state_q)
            StCfg1: st_d = pend ? StCfg1 : StCfg2;
            StCfg2: st_d = pend ? StCfg1 : (BAUD_VAL_FRCTN_EN ? StCfg3 : StPoll);
            StCfg3: st_d = pend ? StCfg1 : StPoll;
            StPoll: begin
                if (pend)                           st_d = StCfg1;
                else if (PRDATA[1] && !rx_valid_q)  st_d = StRxRd;
                else if (PRDATA[0] && (tx0_valid || tx1_valid)) st_d = StTxWr;
                else                                st_d = StPoll;
            end
            StRxRd: st_d = StPoll;
            StTxWr: st_d = StPoll;
            default: st_d = StCfg1;
        endcase

        // Out of reset there is no transfer to complete; start the current state.
        issue_st = psel_q ? st_d : state_q;

        issue_write = 1'b1;
        issue_addr  = AddrStat;
        issue_wdata = 8'h00;
        unique case (issue_st)
            StCfg1: begin
                issue_addr  = AddrCtrl1;
                issue_wdata = BAUD_VALUE[7:0];
            end
            StCfg2: begin
                issue_addr  = AddrCtrl2;
                issue_wdata = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
            end
            StCfg3: begin
                issue_addr  = AddrFrac;
                issue_wdata = {5'b00000, BAUD_VAL_FRCTN};
            end
            StPoll: begin
                issue_write = 1'b0;
                issue_addr  = AddrStat;
            end
            StRxRd: begin
                issue_write = 1'b0;
                issue_addr  = AddrRx;
            end
            StTxWr: begin
                issue_addr  = AddrTx;
                issue_wdata = gnt_sel ? tx1_data : tx0_data;
            end
            default: begin
                issue_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StCfg1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 5'h00;
            pwdata_q   <= 8'h00;
            cfg_done_q <= 1'b0;
            pend_q     <= 1'b0;
            ptr_q      <= 1'b1;
            grant_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_err_q   <= 3'b000;
            stat_err_q <= 3'b000;
        end else begin
            if (cfg_start) pend_q <= 1'b1;
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

            if (!psel_q || (penable_q && PREADY)) begin
                if (psel_q) begin
                    // Completion of the transfer owned by state_q.
                    state_q <= st_d;
                    unique case (state_q)
                        StCfg1, StCfg2, StCfg3: begin
                            if (pend) pend_q <= 1'b0;
                            else if (st_d == StPoll) cfg_done_q <= 1'b1;
                        end
                        StPoll: begin
                            stat_err_q <= PRDATA[4:2];
                            if (pend) begin
                                pend_q     <= 1'b0;
                                cfg_done_q <= 1'b0;
                            end
                        end
                        StRxRd: begin
                            rx_data_q  <= PRDATA;
                            rx_err_q   <= stat_err_q;
                            rx_valid_q <= 1'b1;
                        end
                        StTxWr: ptr_q <= grant_q;
                        default: ;
                    endcase
                end
                // Every completion is followed directly by the next SETUP.
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                pwrite_q  <= issue_write;
                paddr_q   <= issue_addr;
                pwdata_q  <= issue_wdata;
                if (issue_st == StTxWr) grant_q <= gnt_sel;
            end else if (!penable_q) begin
                penable_q <= 1'b1;
            end
        end
    end

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign cfg_done = cfg_done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_err   = rx_err_q;

    // Accept pulses coincide with the ACCESS cycle that completes the write.
    assign tx0_ready = (state_q == StTxWr) && penable_q && PREADY && !grant_q;
    assign tx1_ready = (state_q == StTxWr) && penable_q && PREADY && grant_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Self-checking bench for uart_apb_sequencer: a table of status/requester
// vectors with expected next non-poll transfer, plus hand sequences for
// configuration latency, RX back-pressure, PREADY stalls and mid-transfer reset.
module tb_uart_apb_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_done;
    logic       tx0_valid = 1'b0, tx1_valid = 1'b0;
    logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
    logic       tx0_ready, tx1_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rx_ready = 1'b1;

    logic [7:0] status_v = 8'h00;
    logic [7:0] rxb_v = 8'h00;

    // Fraction-enabled instance, used for configuration checks only.
    logic       f_psel, f_penable, f_pwrite, f_cfg_done, f_tx0_ready, f_tx1_ready;
    logic       f_rx_valid;
    logic [4:0] f_paddr;
    logic [7:0] f_pwdata, f_rx_data;
    logic [2:0] f_rx_err;

    int errors = 0;
    int checks = 0;
    int p0 = 0;
    int p1 = 0;

    always #5 PCLK = ~PCLK;

    // Minimal UART slave: status and RX byte come from bench variables.
    assign PRDATA = (PADDR == 5'h10) ? status_v : ((PADDR == 5'h04) ? rxb_v : 8'h00);

    uart_apb_sequencer #(
        .BAUD_VALUE(13'h1A5), .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b1),
        .BAUD_VAL_FRCTN_EN(1'b0), .BAUD_VAL_FRCTN(3'd0)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .cfg_start(cfg_start), .cfg_done(cfg_done),
        .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
        .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready)
    );

    uart_apb_sequencer #(
        .BAUD_VALUE(13'h1A5), .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b1),
        .BAUD_VAL_FRCTN_EN(1'b1), .BAUD_VAL_FRCTN(3'd5)
    ) dut_f (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(f_psel), .PENABLE(f_penable), .PWRITE(f_pwrite),
        .PADDR(f_paddr), .PWDATA(f_pwdata), .PRDATA(8'h00), .PREADY(PREADY),
        .cfg_start(1'b0), .cfg_done(f_cfg_done),
        .tx0_valid(1'b0), .tx0_data(8'h00), .tx0_ready(f_tx0_ready),
        .tx1_valid(1'b0), .tx1_data(8'h00), .tx1_ready(f_tx1_ready),
        .rx_valid(f_rx_valid), .rx_data(f_rx_data), .rx_err(f_rx_err), .rx_ready(1'b1)
    );

    // Count accept pulses well away from both clock edges.
    always @(negedge PCLK) begin
        #2;
        if (tx0_ready === 1'b1) p0++;
        if (tx1_ready === 1'b1) p1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge PCLK);
        #1;
    endtask

    // Waits for the next completing ACCESS cycle; d is PWDATA or PRDATA.
    task automatic wait_xfer(output logic ok, output logic w, output logic [4:0] a,
                             output logic [7:0] d, output logic r0, output logic r1);
        ok = 1'b0; w = 1'b0; a = 5'h00; d = 8'h00; r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cyc();
            if (PSEL && PENABLE && PREADY) begin
                ok = 1'b1;
                w  = PWRITE;
                a  = PADDR;
                d  = PWRITE ? PWDATA : PRDATA;
                r0 = tx0_ready;
                r1 = tx1_ready;
            end
        end
        if (!ok) chk("xfer_timeout", 64'd0, 64'd1);
    endtask

    task automatic next_nonpoll(output logic w, output logic [4:0] a, output logic [7:0] d,
                                output logic r0, output logic r1);
        logic ok;
        logic done;
        done = 1'b0;
        w = 1'b0; a = 5'h10; d = 8'h00; r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            wait_xfer(ok, w, a, d, r0, r1);
            if (!ok || a != 5'h10) done = 1'b1;
        end
        if (!done) chk("nonpoll_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [7:0] status;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic [7:0] rxb;
        logic       ew;
        logic [4:0] ea;
        logic [7:0] ed;
        logic       er0;
        logic       er1;
        logic       chk_rx;
        logic [7:0] erxd;
        logic [2:0] erxe;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic       ok, w, r0, r1, found;
        logic [4:0] a;
        logic [7:0] d;
        int         nonpoll;

        tbl[0] = '{8'h01, 1'b1, 8'h11, 1'b1, 8'h22, 8'h00, 1'b1, 5'h00, 8'h11, 1'b1, 1'b0,
                   1'b0, 8'h00, 3'b000};
        tbl[1] = '{8'h01, 1'b1, 8'h11, 1'b1, 8'h22, 8'h00, 1'b1, 5'h00, 8'h22, 1'b0, 1'b1,
                   1'b0, 8'h00, 3'b000};
        tbl[2] = '{8'h01, 1'b1, 8'h11, 1'b1, 8'h22, 8'h00, 1'b1, 5'h00, 8'h11, 1'b1, 1'b0,
                   1'b0, 8'h00, 3'b000};
        tbl[3] = '{8'h01, 1'b1, 8'h11, 1'b1, 8'h22, 8'h00, 1'b1, 5'h00, 8'h22, 1'b0, 1'b1,
                   1'b0, 8'h00, 3'b000};
        tbl[4] = '{8'h03, 1'b1, 8'h33, 1'b0, 8'h00, 8'h5A, 1'b0, 5'h04, 8'h5A, 1'b0, 1'b0,
                   1'b1, 8'h5A, 3'b000};
        tbl[5] = '{8'h01, 1'b1, 8'h33, 1'b0, 8'h00, 8'h00, 1'b1, 5'h00, 8'h33, 1'b1, 1'b0,
                   1'b0, 8'h00, 3'b000};
        tbl[6] = '{8'h1E, 1'b0, 8'h00, 1'b0, 8'h00, 8'hC3, 1'b0, 5'h04, 8'hC3, 1'b0, 1'b0,
                   1'b1, 8'hC3, 3'b111};
        tbl[7] = '{8'h01, 1'b0, 8'h00, 1'b1, 8'h44, 8'h00, 1'b1, 5'h00, 8'h44, 1'b0, 1'b1,
                   1'b0, 8'h00, 3'b000};
        tbl[8] = '{8'h01, 1'b1, 8'h55, 1'b1, 8'h66, 8'h00, 1'b1, 5'h00, 8'h55, 1'b1, 1'b0,
                   1'b0, 8'h00, 3'b000};

        // Reset state.
        repeat (3) cyc();
        chk("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
        chk("reset_status", {cfg_done, rx_valid, rx_data, rx_err, tx0_ready, tx1_ready}, 64'd0);
        chk("reset_frac_inst", {f_psel, f_cfg_done}, 64'd0);

        // Configuration latency; cycle 0 is the first edge with PRESET low.
        @(negedge PCLK);
        PRESET = 1'b0;
        cyc();  // cycle 0
        chk("cfg1_setup", {PSEL, PENABLE}, 64'b10);
        cyc();  // cycle 1
        chk("cfg1_write", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 5'h08, 8'hA5});
        cyc();  // cycle 2
        cyc();  // cycle 3
        chk("cfg2_write", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 5'h0C, 8'h0F});
        chk("cfg_done_c3", cfg_done, 64'd0);
        cyc();  // cycle 4
        chk("cfg_done_c4", cfg_done, 64'd1);
        chk("frac_done_c4", f_cfg_done, 64'd0);
        cyc();  // cycle 5
        chk("poll_read_1", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 5'h10});
        chk("frac_write", {f_psel, f_penable, f_pwrite, f_paddr, f_pwdata},
            {3'b111, 5'h14, 8'h05});
        chk("frac_done_c5", f_cfg_done, 64'd0);
        cyc();  // cycle 6
        chk("frac_done_c6", f_cfg_done, 64'd1);
        cyc();  // cycle 7
        chk("poll_read_2", {PSEL, PENABLE, PWRITE, PADDR}, {3'b110, 5'h10});

        // Table: each vector's stimulus yields one expected non-poll transfer.
        for (int k = 0; k < 9; k++) begin
            status_v  = tbl[k].status;
            tx0_valid = tbl[k].v0;
            tx0_data  = tbl[k].d0;
            tx1_valid = tbl[k].v1;
            tx1_data  = tbl[k].d1;
            rxb_v     = tbl[k].rxb;
            next_nonpoll(w, a, d, r0, r1);
            chk($sformatf("vec%0d_xfer", k), {w, a, d, r0, r1},
                {tbl[k].ew, tbl[k].ea, tbl[k].ed, tbl[k].er0, tbl[k].er1});
            cyc();
            if (tbl[k].chk_rx)
                chk($sformatf("vec%0d_rx", k), {rx_valid, rx_data, rx_err},
                    {1'b1, tbl[k].erxd, tbl[k].erxe});
        end

        // RX back-pressure: one read only while rx_valid is held.
        tx0_valid = 1'b0;
        tx1_valid = 1'b0;
        rx_ready  = 1'b0;
        status_v  = 8'h02;
        rxb_v     = 8'h77;
        next_nonpoll(w, a, d, r0, r1);
        chk("rx_hold_first", {w, a, d}, {1'b0, 5'h04, 8'h77});
        nonpoll = 0;
        for (int i = 0; i < 6; i++) begin
            wait_xfer(ok, w, a, d, r0, r1);
            if (a != 5'h10) nonpoll++;
        end
        chk("rx_hold_polls_only", nonpoll, 64'd0);
        chk("rx_hold_valid", {rx_valid, rx_data}, {1'b1, 8'h77});
        rx_ready = 1'b1;
        rxb_v    = 8'h78;
        next_nonpoll(w, a, d, r0, r1);
        chk("rx_hold_second", {w, a, d}, {1'b0, 5'h04, 8'h78});
        status_v = 8'h00;
        cyc();
        chk("rx_second_data", {rx_valid, rx_data}, {1'b1, 8'h78});

        // PREADY stall on a TX write, with cfg_start arriving mid-write.
        status_v  = 8'h01;
        tx0_valid = 1'b1;
        tx0_data  = 8'h99;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (PSEL && !PENABLE && PADDR == 5'h00 && PWRITE) found = 1'b1;
        end
        chk("stall_setup_found", found, 64'd1);
        PREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("stall_c%0d", k),
                {PSEL, PENABLE, PADDR, PWDATA, tx0_ready, tx1_ready},
                {2'b11, 5'h00, 8'h99, 2'b00});
            cfg_start = (k == 0);
        end
        cyc();
        PREADY = 1'b1;
        #1;
        chk("stall_accept", {PADDR, PWDATA, tx0_ready, tx1_ready}, {5'h00, 8'h99, 2'b10});
        cyc();
        tx0_valid = 1'b0;
        wait_xfer(ok, w, a, d, r0, r1);
        chk("restart_poll_first", {w, a}, {1'b0, 5'h10});
        chk("restart_done_held", cfg_done, 64'd1);
        wait_xfer(ok, w, a, d, r0, r1);
        chk("restart_cfg1", {w, a, d}, {1'b1, 5'h08, 8'hA5});
        chk("restart_done_clr", cfg_done, 64'd0);

        // Reset during a stalled ACCESS cycle.
        PREADY = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (PSEL && PENABLE) found = 1'b1;
        end
        chk("midreset_access_found", found, 64'd1);
        PRESET = 1'b1;
        cyc();
        chk("midreset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
        chk("midreset_status", {cfg_done, rx_valid, rx_data, rx_err, tx0_ready, tx1_ready},
            64'd0);
        PREADY    = 1'b1;
        status_v  = 8'h01;
        tx0_valid = 1'b1;
        tx0_data  = 8'hAB;
        tx1_valid = 1'b1;
        tx1_data  = 8'hCD;
        @(negedge PCLK);
        PRESET = 1'b0;
        next_nonpoll(w, a, d, r0, r1);
        chk("post_reset_cfg1", {w, a, d}, {1'b1, 5'h08, 8'hA5});
        next_nonpoll(w, a, d, r0, r1);
        chk("post_reset_cfg2", {w, a, d}, {1'b1, 5'h0C, 8'h0F});
        next_nonpoll(w, a, d, r0, r1);
        // Pointer is back at tx1, so tx0 wins although it won last before reset.
        chk("post_reset_rr", {w, a, d, r0, r1}, {1'b1, 5'h00, 8'hAB, 2'b10});
        tx0_valid = 1'b0;
        tx1_valid = 1'b0;
        chk("post_reset_done", cfg_done, 64'd1);

        repeat (8) cyc();
        chk("tx0_pulse_count", p0, 64'd6);
        chk("tx1_pulse_count", p1, 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
